// File: rtl/trap_ctrl_pkg.sv
// Shared trap sequencer definitions: CSR addresses, cause codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] TRAP_CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] TRAP_CAUSE_BREAK    = 32'd3;
    localparam logic [31:0] TRAP_CAUSE_ECALL    = 32'd11;
    localparam logic [31:0] TRAP_CAUSE_IRQ_SOFT = 32'h8000_0003;
    localparam logic [31:0] TRAP_CAUSE_IRQ_TMR  = 32'h8000_0007;
    localparam logic [31:0] TRAP_CAUSE_IRQ_EXT  = 32'h8000_000B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_W_MTVAL,
        ST_W_MSTATUS,
        ST_JUMP,
        ST_R_MSTATUS,
        ST_RJUMP
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl_prio.sv
// Trap arbitration: picks mret, exception or interrupt and derives cause/epc/tval.
// Latency: purely combinational.
// Backpressure: none; the caller gates hx_valid_i to the accept point.
module trap_ctrl_prio
    import trap_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            hx_valid_i,
    input  logic            mret_i,
    input  logic            illegal_i,
    input  logic            ebreak_i,
    input  logic            ecall_i,
    input  logic            ext_irq_i,
    input  logic            tmr_irq_i,
    input  logic            soft_irq_i,
    input  logic            mie_i,
    input  logic [PC_W-1:0] inst_pc_i,
    input  logic [PC_W-1:0] next_pc_i,
    input  logic [31:0]     inst_i,
    output logic            take_trap_o,
    output logic            take_mret_o,
    output logic [31:0]     cause_o,
    output logic [PC_W-1:0] epc_o,
    output logic [PC_W-1:0] tval_o
);

    // Fixed priority: mret, then exceptions, then interrupts gated by MIE.
    always_comb begin
        take_trap_o = 1'b0;
        take_mret_o = 1'b0;
        cause_o     = '0;
        epc_o       = '0;
        tval_o      = '0;
        if (hx_valid_i) begin
            if (mret_i) begin
                take_mret_o = 1'b1;
            end else if (illegal_i) begin
                take_trap_o = 1'b1;
                cause_o     = TRAP_CAUSE_ILLEGAL;
                epc_o       = inst_pc_i;
                tval_o      = PC_W'(inst_i);
            end else if (ebreak_i) begin
                take_trap_o = 1'b1;
                cause_o     = TRAP_CAUSE_BREAK;
                epc_o       = inst_pc_i;
                tval_o      = inst_pc_i;
            end else if (ecall_i) begin
                take_trap_o = 1'b1;
                cause_o     = TRAP_CAUSE_ECALL;
                epc_o       = inst_pc_i;
            end else if (mie_i && (ext_irq_i || soft_irq_i || tmr_irq_i)) begin
                // Interrupts resume at the instruction that has not yet executed.
                take_trap_o = 1'b1;
                epc_o       = next_pc_i;
                if (ext_irq_i)       cause_o = TRAP_CAUSE_IRQ_EXT;
                else if (soft_irq_i) cause_o = TRAP_CAUSE_IRQ_SOFT;
                else                 cause_o = TRAP_CAUSE_IRQ_TMR;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: writes mepc/mcause/mtval/mstatus then redirects to mtvec, or handles mret.
// Latency: redirect 5 cycles after accept for a trap, 2 for mret; TRAP_VECTORED_EN enables vectored interrupts.
// Backpressure: holds trap_stall_o from accept until the redirect cycle; requests while busy are ignored.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hx_valid_i,
    input  logic [PC_W-1:0] inst_pc_i,
    input  logic [PC_W-1:0] next_pc_i,
    input  logic [31:0]     inst_i,
    input  logic            ecall_i,
    input  logic            ebreak_i,
    input  logic            illegal_i,
    input  logic            mret_i,
    input  logic            ex_trap_valid_i,
    input  logic            tcmp_trap_valid_i,
    input  logic            soft_trap_valid_i,
    input  logic            mstatus_mie_i,
    output logic            trap_csr_we_o,
    output logic [11:0]     trap_csr_addr_o,
    output logic [PC_W-1:0] trap_csr_wdata_o,
    input  logic [PC_W-1:0] trap_csr_rdata_i,
    output logic            trap_stall_o,
    output logic            trap_jump_o,
    output logic [PC_W-1:0] trap_jump_pc_o
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    trap_state_e     state_q, state_d;
    logic [31:0]     cause_q;
    logic [PC_W-1:0] epc_q, tval_q;

    logic            take_trap, take_mret;
    logic [31:0]     prio_cause;
    logic [PC_W-1:0] prio_epc, prio_tval;
    logic [PC_W-1:0] vec_base;

    trap_ctrl_prio #(.PC_W(PC_W)) u_prio (
        .hx_valid_i  (hx_valid_i && (state_q == ST_IDLE)),
        .mret_i      (mret_i),
        .illegal_i   (illegal_i),
        .ebreak_i    (ebreak_i),
        .ecall_i     (ecall_i),
        .ext_irq_i   (ex_trap_valid_i),
        .tmr_irq_i   (tcmp_trap_valid_i),
        .soft_irq_i  (soft_trap_valid_i),
        .mie_i       (mstatus_mie_i),
        .inst_pc_i   (inst_pc_i),
        .next_pc_i   (next_pc_i),
        .inst_i      (inst_i),
        .take_trap_o (take_trap),
        .take_mret_o (take_mret),
        .cause_o     (prio_cause),
        .epc_o       (prio_epc),
        .tval_o      (prio_tval)
    );

    assign vec_base     = trap_csr_rdata_i & ALIGN_MASK;
    assign trap_stall_o = take_trap || take_mret || (state_q != ST_IDLE);

    // State register and trap context captured at the accept point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take_trap) begin
                cause_q <= prio_cause;
                epc_q   <= prio_epc;
                tval_q  <= prio_tval;
            end
        end
    end

    // Next state and CSR channel drive, one CSR access per state.
    always_comb begin
        state_d          = state_q;
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = '0;
        trap_csr_wdata_o = '0;
        trap_jump_o      = 1'b0;
        trap_jump_pc_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (take_trap)      state_d = ST_W_MEPC;
                else if (take_mret) state_d = ST_R_MSTATUS;
            end
            ST_W_MEPC: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MEPC;
                trap_csr_wdata_o = epc_q;
                state_d          = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MCAUSE;
                trap_csr_wdata_o = PC_W'(cause_q);
                state_d          = ST_W_MTVAL;
            end
            ST_W_MTVAL: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MTVAL;
                trap_csr_wdata_o = tval_q;
                state_d          = ST_W_MSTATUS;
            end
            ST_W_MSTATUS: begin
                // MPIE <= MIE, MIE <= 0.
                trap_csr_we_o       = 1'b1;
                trap_csr_addr_o     = CSR_MSTATUS;
                trap_csr_wdata_o[7] = trap_csr_rdata_i[3];
                state_d             = ST_JUMP;
            end
            ST_JUMP: begin
                trap_csr_addr_o = CSR_MTVEC;
                trap_jump_o     = 1'b1;
                trap_jump_pc_o  = vec_base;
`ifdef TRAP_VECTORED_EN
                if (trap_csr_rdata_i[1:0] == 2'b01 && cause_q[31])
                    trap_jump_pc_o = vec_base + PC_W'({cause_q[30:0], 2'b00});
`endif
                state_d = ST_IDLE;
            end
            ST_R_MSTATUS: begin
                // MIE <= MPIE, MPIE <= 1.
                trap_csr_we_o       = 1'b1;
                trap_csr_addr_o     = CSR_MSTATUS;
                trap_csr_wdata_o[3] = trap_csr_rdata_i[7];
                trap_csr_wdata_o[7] = 1'b1;
                state_d             = ST_RJUMP;
            end
            ST_RJUMP: begin
                trap_csr_addr_o = CSR_MEPC;
                trap_jump_o     = 1'b1;
                trap_jump_pc_o  = vec_base;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer between the execute/writeback stage and the CSR file.
- Consumes the CSR file's masked interrupt requests (external, timer, software) and the global MIE bit, plus synchronous exception and mret indications from idex.
- Drives the CSR file's trap write/read channel in a fixed multi-cycle sequence, stalls the pipeline, then issues a PC redirect to the handler or to the return address.

Parameters:
- PC_W, 32, width of PC and CSR data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- hx_valid_i  in  1  instruction retiring this cycle; this is the only trap-accept point
- inst_pc_i  in  PC_W  PC of the retiring instruction
- next_pc_i  in  PC_W  PC of the next instruction to execute
- inst_i  in  32  retiring instruction word, used for mtval
- ecall_i / ebreak_i / illegal_i / mret_i  in  1 each  exception/return flags for the retiring instruction
- ex_trap_valid_i / tcmp_trap_valid_i / soft_trap_valid_i  in  1 each  masked interrupt requests from the CSR file
- mstatus_mie_i  in  1  global interrupt enable
- trap_csr_we_o  out  1  trap CSR write enable
- trap_csr_addr_o  out  12  trap CSR address
- trap_csr_wdata_o  out  PC_W  trap CSR write data
- trap_csr_rdata_i  in  PC_W  trap CSR read data (combinational from trap_csr_addr_o)
- trap_stall_o  out  1  hold the pipeline; blocks idex CSR writes
- trap_jump_o  out  1  one-cycle PC redirect strobe
- trap_jump_pc_o  out  PC_W  redirect target

Behaviour:
- Reset: state IDLE; all outputs 0; latched cause/epc/tval cleared. A reset mid-sequence aborts it and returns to IDLE; no partial-write recovery.
- Accept (IDLE only, qualified by hx_valid_i). Priority, highest first:
  - mret_i
  - illegal_i: cause 2, mtval = inst_i
  - ebreak_i: cause 3, mtval = inst_pc_i
  - ecall_i: cause 11, mtval = 0
  - interrupts, only if mstatus_mie_i: external 0x8000000B > software 0x80000003 > timer 0x80000007; mtval = 0
- Latch on accept: cause; epc = inst_pc_i for exceptions, next_pc_i for interrupts; tval.
- trap_stall_o = accept | (state != IDLE). Purely combinational.
- Trap path, one state per cycle, trap_csr_we_o = 1 in each write state:
  - W_MEPC: write epc.
  - W_MCAUSE: write cause.
  - W_MTVAL: write tval.
  - W_MSTATUS: addr = mstatus; wdata bit7 = rdata bit3, bit3 = 0, all other bits 0.
  - JUMP: addr = mtvec, we = 0; trap_jump_o = 1; trap_jump_pc_o = {rdata[31:2], 2'b00}; next state IDLE.
- mret path:
  - R_MSTATUS: write bit3 = rdata bit7, bit7 = 1.
  - RJUMP: addr = mepc; trap_jump_o = 1; target = {rdata[31:2], 2'b00}; next state IDLE.
- Latency from accept cycle to trap_jump_o: 5 cycles for a trap, 2 cycles for mret.
- Outside write states: trap_csr_we_o = 0, trap_csr_wdata_o = 0. trap_csr_addr_o = 0 in IDLE.
- Requests arriving while busy are ignored; interrupt inputs are level, so they are re-evaluated at the next accept.
- An interrupt that drops after accept does not cancel the sequence.
- Simultaneous exception and interrupt: the exception is taken; the interrupt stays pending (MIE now 0) until mret.
- Simultaneous mret and interrupt: mret is taken; the interrupt can be taken at the next retirement.
- trap_jump_o is high for exactly one cycle per sequence.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: if mtvec[1:0] == 2'b01 and the cause is an interrupt, target = {mtvec[31:2], 2'b00} + 4 × cause[30:0]. Exceptions always use the base address.
- Undefined: mtvec[1:0] is ignored; direct mode only.

Decomposition:
- Shared defines include (existing CSR_* address macros) gains TRAP_CAUSE_* codes (2, 3, 11, 0x80000003/7/B) and the state encodings.
- A small combinational sub-module trap_prio (request flags → cause, epc select, tval) separates arbitration from the FSM.

Test Plan:
- ecall at inst_pc 0x100, mtvec 0x200, MIE=1 → writes mepc=0x100, mcause=11, mtval=0, mstatus=0x80; trap_jump_o with 0x200 five cycles after accept; stall high for all 6 cycles.
- Timer request, MIE=1, next_pc 0x108 → mepc=0x108, mcause=0x80000007; with MIE=0 → no writes, no stall.
- External and timer requests together → mcause=0x8000000B. illegal with timer pending → mcause=2, mtval=inst_i.
- mret with mepc=0x108, MPIE=1 → mstatus bit3=1, bit7=1; jump to 0x108 two cycles after accept.
- TRAP_VECTORED_EN, mtvec=0x201, timer interrupt → target 0x21C. ecall with the same mtvec → 0x200.
- rst_n asserted in W_MCAUSE → all outputs 0 at once; a fresh ecall after release completes normally.
